stopwatch_ctrl: RTL

//  Two-button control sequencer for the BCD stopwatch datapath (sec_ones/sec_tens counter).

---
 rtl/stopwatch_ctrl_if.sv | 28 ++
 rtl/stopwatch_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl_if.sv
`default_nettype none
// ============================================================================
// stopwatch_ctrl_if : button, datapath and display signals of stopwatch_ctrl
// Revision 1.0
// ============================================================================
interface stopwatch_ctrl_if;
    logic       btn_ss;
    logic       btn_lap;
    logic [3:0] cur_ones;
    logic [3:0] cur_tens;
    logic       tick_en;
    logic       clr;
    logic       running;
    logic       lap_valid;
    logic [3:0] disp_ones;
    logic [3:0] disp_tens;

    modport master (
        input  btn_ss, btn_lap, cur_ones, cur_tens,
        output tick_en, clr, running, lap_valid, disp_ones, disp_tens
    );

    modport slave (
        output btn_ss, btn_lap, cur_ones, cur_tens,
        input  tick_en, clr, running, lap_valid, disp_ones, disp_tens
    );
endinterface
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// stopwatch_ctrl : button debounce, run/split/pause FSM, tick prescaler, lap hold
// Revision 1.0
// ============================================================================
module stopwatch_ctrl #(
    parameter int DEBOUNCE_CYC = 16,
    parameter int TICK_DIV     = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    stopwatch_ctrl_if.master sw
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
    localparam int PRE_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        SPLIT = 2'd2,
        PAUSE = 2'd3
    } state_t;

    logic [1:0] raw;
    logic [1:0] press;

    assign raw = {sw.btn_lap, sw.btn_ss};

    // Bit 0 is START/STOP, bit 1 is LAP/RESET.
    for (genvar i = 0; i < 2; i++) begin : g_btn
        logic             sync1;
        logic             sync2;
        logic             deb;
        logic             deb_d;
        logic [CNT_W-1:0] stable_cnt;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                sync1      <= 1'b0;
                sync2      <= 1'b0;
                deb        <= 1'b0;
                deb_d      <= 1'b0;
                stable_cnt <= '0;
            end else begin
                sync1 <= raw[i];
                sync2 <= sync1;
                deb_d <= deb;
                if (sync2 == deb) begin
                    stable_cnt <= '0;
                end else if (stable_cnt == DEB_LAST) begin
                    deb        <= sync2;
                    stable_cnt <= '0;
                end else begin
                    stable_cnt <= stable_cnt + CNT_W'(1);
                end
            end
        end

        assign press[i] = deb & ~deb_d;
    end

    state_t     state;
    state_t     state_nx;
    logic       ss_ev;
    logic       lap_ev;
    logic       capture;
    logic       do_clr;
    logic       cur_run;
    logic       nx_run;
    logic [PRE_W-1:0] presc;
    logic [3:0] lap_ones;
    logic [3:0] lap_tens;
    logic       tick_flag;
    logic       clr_flag;
    logic       run_flag;
    logic       lap_flag;

    // A simultaneous LAP press is dropped in favour of START/STOP.
    assign ss_ev  = press[0];
    assign lap_ev = press[1] & ~press[0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        capture  = 1'b0;
        do_clr   = 1'b0;
        case (state)
            IDLE: begin
                if (ss_ev) state_nx = RUN;
            end
            RUN: begin
                if (ss_ev) begin
                    state_nx = PAUSE;
                end else if (lap_ev) begin
                    state_nx = SPLIT;
                    capture  = 1'b1;
                end
            end
            SPLIT: begin
                if (ss_ev)       state_nx = PAUSE;
                else if (lap_ev) state_nx = RUN;
            end
            PAUSE: begin
                if (ss_ev) begin
                    state_nx = RUN;
                end else if (lap_ev) begin
                    state_nx = IDLE;
                    do_clr   = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign cur_run = (state == RUN) || (state == SPLIT);
    assign nx_run  = (state_nx == RUN) || (state_nx == SPLIT);

    // Prescaler advances only on edges that stay running, so the stop edge
    // freezes the partial count and the start edge does not consume a clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc     <= '0;
            tick_flag <= 1'b0;
            clr_flag  <= 1'b0;
            run_flag  <= 1'b0;
            lap_flag  <= 1'b0;
            lap_ones  <= 4'd0;
            lap_tens  <= 4'd0;
        end else begin
            tick_flag <= 1'b0;
            clr_flag  <= do_clr;
            run_flag  <= nx_run;
            lap_flag  <= (state_nx == SPLIT);
            if (state_nx == IDLE) begin
                presc <= '0;
            end else if (cur_run && nx_run) begin
                if (presc == PRE_LAST) begin
                    presc     <= '0;
                    tick_flag <= 1'b1;
                end else begin
                    presc <= presc + PRE_W'(1);
                end
            end
            if (do_clr) begin
                lap_ones <= 4'd0;
                lap_tens <= 4'd0;
            end else if (capture) begin
                lap_ones <= sw.cur_ones;
                lap_tens <= sw.cur_tens;
            end
        end
    end

    assign sw.tick_en   = tick_flag;
    assign sw.clr       = clr_flag;
    assign sw.running   = run_flag;
    assign sw.lap_valid = lap_flag;
    assign sw.disp_ones = lap_flag ? lap_ones : sw.cur_ones;
    assign sw.disp_tens = lap_flag ? lap_tens : sw.cur_tens;
endmodule
`default_nettype wire
